// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder: state encoding, default sizing
// and the address range helper.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int unsigned MEM_ADDR_WIDTH  = 9;
    localparam int unsigned MEM_DATA_WIDTH  = 32;
    localparam int unsigned MEM_DEPTH       = 512;
    localparam int unsigned MEM_WAIT_CYCLES = 2;
    localparam int unsigned CNT_WIDTH       = 4;

    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/memory_responder_if.sv
// Handshake/bus bundle between the control unit (master) and the memory responder (slave).
interface memory_responder_if #(
    parameter int AW = 9,
    parameter int DW = 32
);
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          mem_done;
    logic          mem_busy;
    logic          mem_err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, mem_done, mem_busy, mem_err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, mem_done, mem_busy, mem_err
    );
endinterface

// File: rtl/memory_responder_ram_array.sv
// Synchronous single-port RAM, read-before-write, contents survive reset.
module ram_array #(
    parameter int AW    = 9,
    parameter int DW    = 32,
    parameter int DEPTH = 512
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);
    logic [DW-1:0] mem_q [DEPTH];

    // Storage array write and registered read port.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= din;
        end
        dout <= mem_q[addr];
    end
endmodule

// File: rtl/memory_responder.sv
// Memory-side handshake engine: latches a request, waits WAIT_CYCLES, performs the
// RAM access and pulses mem_done (plus mem_err for bad requests).
module memory_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
    parameter int DEPTH       = MEM_DEPTH,
    parameter int WAIT_CYCLES = MEM_WAIT_CYCLES
) (
    input  logic              clock,
    input  logic              reset,
    memory_responder_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] WAIT_INIT = CNT_WIDTH'(WAIT_CYCLES);

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    is_read_q, is_read_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;

    logic                    ram_we_s;
    logic [ADDR_WIDTH-1:0]   ram_addr_s;
    logic [DATA_WIDTH-1:0]   ram_dout_s;
    logic                    in_range_s;

    ram_array #(
        .AW    (ADDR_WIDTH),
        .DW    (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock (clock),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .din   (wdata_q),
        .dout  (ram_dout_s)
    );

    // Next-state, datapath latching and RAM control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_read_d  = is_read_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        ram_we_s   = 1'b0;
        in_range_s = addr_in_range(32'(addr_q), DEPTH);
        // In IDLE the RAM already looks at the live address so read data is
        // ready by the access edge even with zero wait states.
        if (state_q == ST_IDLE) begin
            ram_addr_s = bus.addr;
        end else begin
            ram_addr_s = addr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.mem_read ^ bus.mem_write) begin
                    addr_d    = bus.addr;
                    wdata_d   = bus.wdata;
                    is_read_d = bus.mem_read;
                    cnt_d     = WAIT_INIT;
                    state_d   = ST_WAIT;
                end else if (bus.mem_read & bus.mem_write) begin
                    err_d   = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != {CNT_WIDTH{1'b0}}) begin
                    cnt_d = cnt_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    done_d  = 1'b1;
                    err_d   = ~in_range_s;
                    state_d = ST_DONE;
                    if (is_read_q) begin
                        rdata_d = in_range_s ? ram_dout_s : {DATA_WIDTH{1'b0}};
                    end else begin
                        ram_we_s = in_range_s;
                    end
                end
            end
            ST_DONE, ST_HOLD: begin
                if (!bus.mem_read && !bus.mem_write) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_WIDTH{1'b0}};
            addr_q    <= {ADDR_WIDTH{1'b0}};
            wdata_q   <= {DATA_WIDTH{1'b0}};
            is_read_q <= 1'b0;
            rdata_q   <= {DATA_WIDTH{1'b0}};
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_read_q <= is_read_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.mem_done = done_q;
    assign bus.mem_err  = err_q;
    assign bus.mem_busy = busy_q;

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Memory-side end of the CPU memory interface.
- Accepts the control unit's mem_read / mem_write strobes, together with the MAR address and MDR write data, and performs the access on an internal single-port RAM after a programmable number of wait states.
- Signals completion with a one-cycle mem_done pulse and holds read data for the MDR to capture.
- Sits between the datapath's MAR/MDR and the RAM array.

Parameters:
- ADDR_WIDTH, 9, width of address input (from MAR low bits)
- DATA_WIDTH, 32, word width
- DEPTH, 512, number of implemented words; valid addresses are 0..DEPTH-1
- WAIT_CYCLES, 2, extra wait states before the access completes (0..15)

Ports:
- clock  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- mem_read  input  1  read request level from control unit
- mem_write  input  1  write request level from control unit
- addr  input  ADDR_WIDTH  word address (MAR)
- wdata  input  DATA_WIDTH  write data (MDR out)
- rdata  output  DATA_WIDTH  read data to MDR (Mdatain)
- mem_done  output  1  one-cycle completion pulse
- mem_busy  output  1  high whenever state != IDLE
- mem_err  output  1  one-cycle error pulse

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0, rdata=0, mem_done=0, mem_err=0.
  - RAM contents are NOT cleared.
  - Reset asserted mid-access aborts the access; no RAM write occurs.
- States: IDLE, WAIT, DONE, HOLD (encoded in package).
- IDLE:
  - At an edge with exactly one of mem_read/mem_write high: latch addr, wdata and the op; load counter=WAIT_CYCLES; go to WAIT ("accept edge").
  - Both strobes high: mem_err=1 for one cycle, no access, go to HOLD.
  - Neither strobe high: stay in IDLE.
- WAIT, at each edge:
  - counter!=0: decrement.
  - counter==0: perform the access using the latched values, go to DONE.
  - Write: RAM[addr]<=wdata.
  - Read: rdata<=RAM[addr].
- Latency: mem_done is high in the cycle following edge number WAIT_CYCLES+1 after the accept edge. WAIT_CYCLES=0 means done is high after the first edge following accept.
- DONE:
  - mem_done=1 for exactly this one cycle.
  - Next edge: go to IDLE if both strobes are low, else HOLD.
- HOLD: stay until both strobes are sampled low, then go to IDLE. A request is never re-accepted without first dropping; each strobe level yields exactly one access.
- rdata holds its value until the next completed read. Writes and errors do not change rdata.
- Out-of-range addr (addr >= DEPTH):
  - The access still proceeds through WAIT.
  - In DONE, mem_err=1 alongside mem_done=1.
  - A write is discarded; a read returns rdata=0.
- Input changes on addr, wdata or strobes during WAIT are ignored, because values are latched at accept.
- mem_busy = (state != IDLE), registered from state.

Decomposition:
- Package mem_pkg: state encoding constants (IDLE=2'd0, WAIT=2'd1, DONE=2'd2, HOLD=2'd3), default widths, DEPTH.
- Sub-module ram_array: synchronous single-port RAM with we, addr, din, dout and no reset. memory_responder instantiates it and owns all handshake logic.

Test Plan:
- WAIT_CYCLES=2: write addr=0x010, wdata=0xDEADBEEF, strobe held -> mem_done high exactly one cycle after 3rd edge post-accept; mem_busy high from accept through HOLD; mem_err=0.
- Read addr=0x010 after the above -> rdata=0xDEADBEEF coincident with mem_done; rdata stays 0xDEADBEEF through a later write to 0x011.
- Hold mem_read high for 10 cycles after done -> exactly one mem_done; state stays HOLD until strobe drops, then IDLE.
- mem_read=mem_write=1 in IDLE -> mem_err one cycle, no mem_done, RAM[addr] unchanged, rdata unchanged.
- Write addr=0x1FF ok; with DEPTH=256, write addr=0x100 -> mem_done+mem_err; following read of 0x100 -> rdata=0 with mem_err.
- Assert reset=0 during WAIT of a write to 0x020 (prior content 0x12345678) -> outputs 0, state IDLE immediately; read back 0x020 -> 0x12345678. WAIT_CYCLES=0 variant: mem_done one edge after accept.
